// File: rtl/pll_sup_pkg.sv
// Shared types and default parameter values for the PLL lock supervisor.
// Consumed by pll_lock_supervisor and its testbench.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RESET = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABILIZE = 2'd2,
    ST_RUN       = 2'd3
  } pll_sup_state_e;

  localparam int DEF_SYNC_STAGES           = 2;
  localparam int DEF_PLL_RST_CYCLES        = 16;
  localparam int DEF_LOCK_STABLE_CYCLES    = 1024;
  localparam int DEF_RELOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_LOSS_CNT_W            = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// Single-bit multi-flop synchronizer bringing pll_locked into the clk domain.
// STAGES must be at least 2; all flops clear on synchronous reset.
module pll_sup_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: resets the PLL, waits for a stable lock, then releases sys_rst_n.
// Optional macro PLL_SUP_GLITCH_FILTER_EN adds a 3-sample agreement filter on the lock flag.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES           = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES        = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES    = DEF_LOCK_STABLE_CYCLES,
  parameter int RELOCK_TIMEOUT_CYCLES = DEF_RELOCK_TIMEOUT_CYCLES,
  parameter int LOSS_CNT_W            = DEF_LOSS_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  relock_req,
  output logic                  pll_rst,
  output logic                  sys_rst_n,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] loss_cnt
);

  localparam int CNT_MAX = max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, RELOCK_TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t RST_LAST     = cnt_t'(PLL_RST_CYCLES - 1);
  localparam cnt_t STABLE_LAST  = cnt_t'(LOCK_STABLE_CYCLES - 1);
  localparam cnt_t TIMEOUT_LAST = cnt_t'(RELOCK_TIMEOUT_CYCLES - 1);

  logic lk_sync;
  logic lk;

  pll_sup_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (pll_locked),
    .sync_o  (lk_sync)
  );

`ifdef PLL_SUP_GLITCH_FILTER_EN
  // lk only follows the synchronizer once three consecutive samples agree.
  logic [1:0] hist_q;
  logic       filt_q;
  logic       filt_d;

  assign filt_d = (lk_sync == hist_q[0] && lk_sync == hist_q[1]) ? lk_sync : filt_q;
  assign lk     = filt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], lk_sync};
      filt_q <= filt_d;
    end
  end
`else
  assign lk = lk_sync;
`endif

  pll_sup_state_e        state_q;
  cnt_t                  cnt_q;
  logic                  pll_rst_q;
  logic                  sys_rst_n_q;
  logic                  ready_q;
  logic [LOSS_CNT_W-1:0] loss_cnt_q;
  logic [LOSS_CNT_W-1:0] loss_cnt_d;

  assign loss_cnt_d = (&loss_cnt_q) ? loss_cnt_q : loss_cnt_q + 1'b1;

  // Outputs are updated on the same edge as the state so they never disagree.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_PLL_RESET;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      loss_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_PLL_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_q   <= ST_WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (relock_req || (!lk && cnt_q == TIMEOUT_LAST)) begin
            state_q   <= ST_PLL_RESET;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
          end else if (lk) begin
            state_q <= ST_STABILIZE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_STABILIZE: begin
          if (relock_req) begin
            state_q   <= ST_PLL_RESET;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
          end else if (!lk) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            sys_rst_n_q <= 1'b1;
            ready_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lk) begin
            loss_cnt_q <= loss_cnt_d;
          end
          if (relock_req || !lk) begin
            state_q     <= relock_req ? ST_PLL_RESET : ST_WAIT_LOCK;
            cnt_q       <= '0;
            pll_rst_q   <= relock_req;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_PLL_RESET;
          cnt_q       <= '0;
          pll_rst_q   <= 1'b1;
          sys_rst_n_q <= 1'b0;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign loss_cnt  = loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios plus random stimulus,
// every cycle compared against a phase/elapsed-time model of the supervisor behaviour.
module tb_pll_lock_supervisor;

  localparam int SYNC = 2;
  localparam int RSTC = 4;
  localparam int STAB = 8;
  localparam int TMO  = 32;
  localparam int LW   = 2;
  localparam int LOSS_MAX = (1 << LW) - 1;
`ifdef PLL_SUP_GLITCH_FILTER_EN
  localparam int FILT_LAT = 2;
`else
  localparam int FILT_LAT = 0;
`endif

  localparam int PH_RST  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_STAB = 2;
  localparam int PH_RUN  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          pll_locked;
  logic          relock_req;
  logic          pll_rst;
  logic          sys_rst_n;
  logic          ready;
  logic [LW-1:0] loss_cnt;

  pll_lock_supervisor #(
    .SYNC_STAGES           (SYNC),
    .PLL_RST_CYCLES        (RSTC),
    .LOCK_STABLE_CYCLES    (STAB),
    .RELOCK_TIMEOUT_CYCLES (TMO),
    .LOSS_CNT_W            (LW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .loss_cnt   (loss_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: which phase we are in and how many edges have passed in it.
  int m_phase;
  int m_elapsed;
  int m_loss;
  bit locked_hist[$];   // pll_locked samples, newest first
  bit m_filt;

  task automatic enter(input int ph);
    m_phase   = ph;
    m_elapsed = 0;
  endtask

  task automatic model_step();
    bit lk;
    if (!rst_n) begin
      enter(PH_RST);
      m_loss = 0;
      m_filt = 1'b0;
      locked_hist = {};
      for (int i = 0; i < SYNC + 3; i++) locked_hist.push_back(1'b0);
      return;
    end
    locked_hist.push_front(pll_locked);
    void'(locked_hist.pop_back());
`ifdef PLL_SUP_GLITCH_FILTER_EN
    if (locked_hist[SYNC] == locked_hist[SYNC+1] && locked_hist[SYNC+1] == locked_hist[SYNC+2])
      m_filt = locked_hist[SYNC];
    lk = m_filt;
`else
    lk = locked_hist[SYNC];
`endif
    m_elapsed++;
    case (m_phase)
      PH_RST:  if (m_elapsed == RSTC) enter(PH_WAIT);
      PH_WAIT: begin
        if (relock_req) enter(PH_RST);
        else if (lk) enter(PH_STAB);
        else if (m_elapsed == TMO) enter(PH_RST);
      end
      PH_STAB: begin
        if (relock_req) enter(PH_RST);
        else if (!lk) enter(PH_WAIT);
        else if (m_elapsed == STAB) enter(PH_RUN);
      end
      default: begin
        if (!lk && m_loss < LOSS_MAX) m_loss++;
        if (relock_req) enter(PH_RST);
        else if (!lk) enter(PH_WAIT);
      end
    endcase
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("pll_rst",   int'(pll_rst),   int'(m_phase == PH_RST));
    check("sys_rst_n", int'(sys_rst_n), int'(m_phase == PH_RUN));
    check("ready",     int'(ready),     int'(m_phase == PH_RUN));
    check("loss_cnt",  int'(loss_cnt),  m_loss);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    run(n);
    rst_n = 1'b1;
  endtask

  int rel, prst, rises, prev, highs, lat, hold;

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b1;
    relock_req = 1'b0;

    // Power-up with a solid lock.
    rst_n = 1'b0;
    run(3);
    check("rst_pll_rst", int'(pll_rst), 1);
    check("rst_loss", int'(loss_cnt), 0);
    prst = int'(pll_rst);
    rst_n = 1'b1;
    rel = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      prst += int'(pll_rst);
      if (ready && rel == 0) rel = i;
    end
    check("pll_rst_len", prst, RSTC);
    check("release_cycle", rel, RSTC + 1 + STAB);
    $display("scenario power_up: release at cycle %0d", rel);

    // Lock drop in RUN: latency to sys_rst_n low, then re-release.
    pll_locked = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      if (i == 4) pll_locked = 1'b1;
      cycle();
      if (!sys_rst_n) lat = i;
    end
    pll_locked = 1'b1;
    check("loss_latency", lat, SYNC + 1 + FILT_LAT);
    check("loss_one", int'(loss_cnt), 1);
    run(30);
    check("rerelease", int'(ready), 1);
    $display("scenario lock_drop: latency %0d", lat);

    // Relock request in RUN: PLL reset next cycle, loss count untouched.
    relock_req = 1'b1;
    cycle();
    relock_req = 1'b0;
    check("relock_pll_rst", int'(pll_rst), 1);
    check("relock_ready", int'(ready), 0);
    check("relock_loss", int'(loss_cnt), 1);
    run(30);
    $display("scenario relock: loss_cnt %0d", loss_cnt);

    // Glitch during STABILIZE restarts the stability count.
    do_reset(1);
    rel = 0;
    for (int i = 1; i <= 40; i++) begin
      pll_locked = (i != 8);
      cycle();
      if (ready && rel == 0) rel = i;
    end
`ifdef PLL_SUP_GLITCH_FILTER_EN
    check("stab_glitch_release", rel, RSTC + 1 + STAB);
`else
    check("stab_glitch_release", rel, 8 + SYNC + 1 + STAB);
`endif
    $display("scenario stabilize_glitch: release at cycle %0d", rel);

    // No lock at all: periodic PLL resets, never ready.
    pll_locked = 1'b0;
    do_reset(1);
    rises = 0;
    highs = 0;
    prev  = int'(pll_rst);
    for (int i = 1; i <= 150; i++) begin
      cycle();
      if (pll_rst && prev == 0) rises++;
      prev = int'(pll_rst);
      highs += int'(ready);
    end
    check("timeout_pulses", rises, 150 / (RSTC + TMO));
    check("never_ready", highs, 0);
    $display("scenario no_lock: %0d re-resets", rises);

    // Five losses saturate a 2-bit counter.
    pll_locked = 1'b1;
    do_reset(2);
    run(30);
    for (int k = 0; k < 5; k++) begin
      pll_locked = 1'b0;
      run(3);
      pll_locked = 1'b1;
      run(30);
    end
    check("loss_saturate", int'(loss_cnt), LOSS_MAX);
    $display("scenario saturation: loss_cnt %0d", loss_cnt);

    // Random traffic against the model.
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        pll_locked = ($urandom_range(0, 3) != 0);
        hold = pll_locked ? int'($urandom_range(5, 80)) : int'($urandom_range(1, 50));
      end
      hold--;
      relock_req = ($urandom_range(0, 79) == 0);
      rst_n      = ($urandom_range(0, 399) != 0);
      cycle();
    end
    rst_n      = 1'b1;
    relock_req = 1'b0;
    $display("scenario random: done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter SYNC_STAGES, 2, synchronizer depth for pll_locked (min 2).
REQ-002 SHALL have parameter PLL_RST_CYCLES, 16, cycles pll_rst is held high per PLL reset.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, 1024, consecutive locked cycles required before release.
REQ-004 SHALL have parameter RELOCK_TIMEOUT_CYCLES, 65536, max wait for lock before re-resetting the PLL.
REQ-005 SHALL have parameter LOSS_CNT_W, 8, width of loss_cnt.
REQ-006 SHALL have port clk  in  1  single clock (50 MHz PLL reference domain).
REQ-007 SHALL have port rst_n  in  1  synchronous, active-low reset.
REQ-008 SHALL have port pll_locked  in  1  PLL lock flag, asynchronous to clk.
REQ-009 SHALL have port relock_req  in  1  single-cycle request to force a PLL reset.
REQ-010 SHALL have port pll_rst  out  1  active-high reset to the PLL.
REQ-011 SHALL have port sys_rst_n  out  1  active-low reset for logic on PLL output clocks.
REQ-012 SHALL have port ready  out  1  high while in RUN.
REQ-013 SHALL have port loss_cnt  out  LOSS_CNT_W  saturating count of lock losses in RUN.

Function
REQ-014 SHALL pass pll_locked through SYNC_STAGES flops; "lk" below is the synchronized (and, if configured, filtered) value.
REQ-015 SHALL implement states PLL_RESET, WAIT_LOCK, STABILIZE, RUN; all outputs registered.
REQ-016 PLL_RESET: pll_rst=1, sys_rst_n=0; after PLL_RST_CYCLES cycles -> WAIT_LOCK with counter cleared.
REQ-017 WAIT_LOCK: pll_rst=0; lk=1 -> STABILIZE (counter cleared); counter reaching RELOCK_TIMEOUT_CYCLES-1 with lk=0 -> PLL_RESET.
REQ-018 STABILIZE: lk=0 -> WAIT_LOCK with timeout restarted; LOCK_STABLE_CYCLES consecutive lk=1 -> RUN.
REQ-019 RUN: sys_rst_n=1, ready=1; lk=0 -> WAIT_LOCK, loss_cnt+1, sys_rst_n=0 and ready=0 on the next edge.
REQ-020 loss_cnt SHALL saturate at all-ones, never wrap.
REQ-021 relock_req in WAIT_LOCK, STABILIZE or RUN -> PLL_RESET next cycle; ignored in PLL_RESET (count not restarted).
REQ-022 relock_req alone in RUN SHALL NOT increment loss_cnt; relock_req and lk=0 in the same RUN cycle -> PLL_RESET and loss_cnt increments.
REQ-023 Latency pll_locked fall to sys_rst_n low in RUN SHALL be SYNC_STAGES+1 cycles (plus filter latency if configured).
REQ-024 sys_rst_n SHALL be 1 only in RUN; no glitch on state entry/exit.

Reset
REQ-025 On rst_n=0 at a clk edge: state PLL_RESET, pll_rst=1, sys_rst_n=0, ready=0, loss_cnt=0, counter=0, synchronizer flops 0.
REQ-026 Reset asserted mid-operation (any state) SHALL take effect on the same edge and restart the full PLL_RESET sequence.

Configuration
REQ-027 Macro PLL_SUP_GLITCH_FILTER_EN defined: lk changes only after 3 consecutive agreeing synchronized samples (+2 cycles latency); single-cycle pll_locked glitches ignored.
REQ-028 Macro undefined: lk is the synchronizer output directly; every low sample in RUN counts as a loss.

Structure
REQ-029 Package pll_sup_pkg SHALL hold the state enum type and default parameter constants.
REQ-030 Synchronizer SHALL be sub-module pll_sup_sync (parameterised depth, single bit); filter and FSM stay in the top module.

Verification (PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, RELOCK_TIMEOUT_CYCLES=32, SYNC_STAGES=2, filter off)
REQ-031 rst_n low 3 cycles then high, pll_locked=1 throughout -> pll_rst high 4 cycles, ready/sys_rst_n rise after 8 stable lk cycles, loss_cnt=0.
REQ-032 pll_locked stays 0 -> pll_rst re-pulses for 4 cycles every 32+4 cycles; ready never 1.
REQ-033 In RUN drop pll_locked 1 cycle -> sys_rst_n low 3 cycles later, loss_cnt=1, re-release after 8 stable cycles.
REQ-034 In STABILIZE drop pll_locked at stable count 5 -> back to WAIT_LOCK, count restarts from 0, ready stays 0.
REQ-035 In RUN pulse relock_req -> PLL_RESET next cycle, loss_cnt unchanged; with LOSS_CNT_W=2, 5 losses -> loss_cnt=3.
REQ-036 Filter on: 1-cycle pll_locked glitch in RUN -> no state change; 3-cycle drop -> loss_cnt=1.
